// File: rtl/clk_div_multi.sv
// Multi-channel clock divider / tick generator: per-channel divisor, enable and toggle/pulse mode.
// Define CLKDIV_ALIGN_EN to make a load on any channel restart (phase-align) every channel.
module clk_div_multi #(
  parameter int CH          = 2,
  parameter int CNT_W       = 33,
  parameter int DEFAULT_DIV = 1040000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CH-1:0]       en,
  input  logic [CH-1:0]       load,
  input  logic [CH*CNT_W-1:0] div_in,
  input  logic [CH-1:0]       mode,
  output logic [CH-1:0]       out,
  output logic [CH-1:0]       tick
);

  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);

  if (CH < 1) begin : g_bad_ch
    $error("clk_div_multi: CH must be at least 1");
  end

  if (DEFAULT_DIV < 0 || (64'(DEFAULT_DIV) >> CNT_W) != 64'd0) begin : g_bad_div
    $error("clk_div_multi: DEFAULT_DIV does not fit in CNT_W bits");
  end

  // Per-cycle decision for one channel, listed in priority order.
  typedef enum logic [2:0] {
    ACT_LOAD,
    ACT_RESTART,
    ACT_HOLD,
    ACT_TERM,
    ACT_COUNT
  } action_t;

  typedef struct packed {
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_q;
    logic             out;
    logic             tick;
  } chan_t;

  logic restart_all;

`ifdef CLKDIV_ALIGN_EN
  assign restart_all = |load;
`else
  assign restart_all = 1'b0;
`endif

  for (genvar i = 0; i < CH; i++) begin : g_ch
    chan_t            cur;
    chan_t            nxt;
    action_t          act;
    logic [CNT_W-1:0] div_new;

    assign div_new = div_in[i*CNT_W +: CNT_W];

    always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      act = ACT_COUNT;
      if (load[i]) begin
        act = ACT_LOAD;
      end else if (restart_all) begin
        act = ACT_RESTART;
      end else if (!en[i]) begin
        act = ACT_HOLD;
      end else if (cur.cnt >= cur.div_q) begin
        // >= rather than == so a count left above the divisor still terminates.
        act = ACT_TERM;
      end
    end

    always_comb begin
      nxt      = cur;
      nxt.tick = 1'b0;
      unique case (act)
        ACT_LOAD: begin
          nxt.div_q = div_new;
          nxt.cnt   = '0;
          nxt.out   = 1'b0;
        end
        ACT_RESTART: begin
          nxt.cnt = '0;
          nxt.out = 1'b0;
        end
        ACT_HOLD: begin
          nxt.cnt = cur.cnt;
        end
        ACT_TERM: begin
          nxt.cnt  = '0;
          nxt.tick = 1'b1;
          nxt.out  = mode[i] ? 1'b1 : ~cur.out;
        end
        ACT_COUNT: begin
          nxt.cnt = cur.cnt + 1'b1;
          if (mode[i]) begin
            nxt.out = 1'b0;
          end
        end
        default: begin
          nxt.cnt = cur.cnt;
        end
      endcase
    end

    // NOTE: the divisor register is reset too, so an asynchronous reset discards any loaded value.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cur <= '{cnt: '0, div_q: DEF_DIV, out: 1'b0, tick: 1'b0};
      end else begin
        // NOTE: state registers use non-blocking assignment so all channels update together.
        cur <= nxt;
      end
    end

    assign out[i]  = cur.out;
    assign tick[i] = cur.tick;
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi: directed steps then randomized traffic against a
// countdown-style reference model; honours CLKDIV_ALIGN_EN when it is defined.
module tb_clk_div_multi;

  localparam int CH          = 2;
  localparam int CNT_W       = 8;
  localparam int DEFAULT_DIV = 3;

  logic                clk;
  logic                reset;
  logic [CH-1:0]       en;
  logic [CH-1:0]       load;
  logic [CH*CNT_W-1:0] div_in;
  logic [CH-1:0]       mode;
  logic [CH-1:0]       out;
  logic [CH-1:0]       tick;

  int errors = 0;
  int checks = 0;

  // Reference model: cycles remaining until the next terminal, plus output levels.
  int m_div [CH];
  int m_rem [CH];
  bit m_out [CH];
  bit m_tick[CH];

  clk_div_multi #(
    .CH         (CH),
    .CNT_W      (CNT_W),
    .DEFAULT_DIV(DEFAULT_DIV)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .load  (load),
    .div_in(div_in),
    .mode  (mode),
    .out   (out),
    .tick  (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_restart(input int i);
    m_rem[i]  = m_div[i];
    m_out[i]  = 1'b0;
    m_tick[i] = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_div[i] = DEFAULT_DIV;
      model_restart(i);
    end
  endtask

  task automatic model_step();
    if (!reset) begin
      model_reset();
      return;
    end
    for (int i = 0; i < CH; i++) begin
      if (load[i]) begin
        m_div[i] = int'(div_in[i*CNT_W +: CNT_W]);
        model_restart(i);
      end
`ifdef CLKDIV_ALIGN_EN
      else if (|load) begin
        model_restart(i);
      end
`endif
      else if (!en[i]) begin
        m_tick[i] = 1'b0;
      end else if (m_rem[i] == 0) begin
        m_rem[i]  = m_div[i];
        m_tick[i] = 1'b1;
        m_out[i]  = mode[i] ? 1'b1 : !m_out[i];
      end else begin
        m_rem[i]  = m_rem[i] - 1;
        m_tick[i] = 1'b0;
        if (mode[i]) m_out[i] = 1'b0;
      end
    end
  endtask

  // One clock: model advances on the edge, DUT is compared on the following falling edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    for (int i = 0; i < CH; i++) begin
      check($sformatf("out[%0d]", i), 32'(out[i]), 32'(m_out[i]));
      check($sformatf("tick[%0d]", i), 32'(tick[i]), 32'(m_tick[i]));
    end
  endtask

  initial begin
    int first_tick;
    int found;

    reset  = 1'b0;
    en     = '0;
    load   = '0;
    div_in = '0;
    mode   = '0;
    model_reset();

    #12;
    check("reset_out", 32'(out), 32'd0);
    check("reset_tick", 32'(tick), 32'd0);

    // Release reset, both channels in toggle mode with the default divisor.
    @(negedge clk);
    reset = 1'b1;
    en    = 2'b11;
    first_tick = -1;
    for (int c = 1; c <= 10; c++) begin
      cycle();
      if (tick[0] === 1'b1 && first_tick < 0) first_tick = c;
    end
    check("first_tick_latency", 32'(first_tick), 32'd4);
    for (int c = 0; c < 12; c++) cycle();

    // Divisor 0 on channel 0: continuous tick, out flips every cycle.
    load   = 2'b01;
    div_in = {8'd0, 8'd0};
    cycle();
    load = '0;
    for (int c = 0; c < 6; c++) begin
      cycle();
      check("div0_tick", 32'(tick[0]), 32'd1);
    end

    // Pulse mode on channel 1 with divisor 4.
    mode   = 2'b10;
    load   = 2'b10;
    div_in = {8'd4, 8'd0};
    cycle();
    load = '0;
    for (int c = 1; c <= 10; c++) begin
      cycle();
      check("pulse_tick1", 32'(tick[1]), 32'((c == 5) || (c == 10)));
    end

    // Freeze channel 0 at cnt=2 with divisor 3, then resume.
    load   = 2'b01;
    div_in = {8'd4, 8'd3};
    cycle();
    load = '0;
    cycle();
    cycle();
    en = 2'b10;
    for (int c = 0; c < 10; c++) begin
      cycle();
      check("frozen_tick0", 32'(tick[0]), 32'd0);
    end
    en = 2'b11;
    cycle();
    check("resume_tick0_a", 32'(tick[0]), 32'd0);
    cycle();
    check("resume_tick0_b", 32'(tick[0]), 32'd1);

    // Load arriving on a terminal-count cycle wins.
    found = 0;
    for (int c = 0; c < 12; c++) begin
      if (m_rem[0] == 0) begin
        found = 1;
        break;
      end
      cycle();
    end
    check("terminal_reached", 32'(found), 32'd1);
    load   = 2'b01;
    div_in = {8'd4, 8'd3};
    cycle();
    check("load_on_term_tick0", 32'(tick[0]), 32'd0);
    check("load_on_term_out0", 32'(out[0]), 32'd0);
    load = '0;
    for (int c = 1; c <= 4; c++) begin
      cycle();
      check("after_load_tick0", 32'(tick[0]), 32'(c == 4));
    end

    // Asynchronous reset while out[0] is high.
    mode  = 2'b00;
    found = 0;
    for (int c = 0; c < 20; c++) begin
      if (m_out[0]) begin
        found = 1;
        break;
      end
      cycle();
    end
    check("out0_high_reached", 32'(found), 32'd1);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check("async_reset_out", 32'(out), 32'd0);
    check("async_reset_tick", 32'(tick), 32'd0);
    cycle();
    reset = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      cycle();
      check("post_reset_tick1", 32'(tick[1]), 32'((c == 4) || (c == 8)));
    end

    // Randomized traffic.
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < CH; i++) begin
        en[i]   = ($urandom_range(0, 9) != 0);
        load[i] = ($urandom_range(0, 29) == 0);
        if ($urandom_range(0, 19) == 0) mode[i] = ~mode[i];
      end
      div_in = {8'($urandom_range(0, 7)), 8'($urandom_range(0, 7))};
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
- Parametrised multi-channel clock divider / tick generator. Each channel has a runtime-loadable divisor, an independent enable and a mode select: square-wave toggle or single-cycle pulse.
- Sits beside the system clock and feeds slow strobes to display scanning, debouncing and game-timing logic.
- All channels run in the clk domain. Outputs are registered enables, not derived clocks.

Parameters:
- CH, 2, number of independent channels (>=1)
- CNT_W, 33, counter and divisor width per channel
- DEFAULT_DIV, 1040000, divisor loaded at reset; must be < 2**CNT_W (elaboration-time check)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-low reset
- en  in  CH  per-channel count enable
- load  in  CH  per-channel divisor load strobe
- div_in  in  CH*CNT_W  divisor values; channel i in slice [i*CNT_W +: CNT_W]
- mode  in  CH  0 = toggle (square wave), 1 = pulse
- out  out  CH  divided output per channel
- tick  out  CH  one-cycle terminal-count strobe per channel

Behaviour:
- Reset is asynchronous, active-low; clock is clk. While reset=0, per channel: cnt=0, div_q=DEFAULT_DIV, out=0, tick=0.
- Per-channel state: cnt[CNT_W], div_q[CNT_W], out reg, tick reg. All updates are on posedge clk.
- Per-channel priority, highest first: load > en=0 > terminal > count.
- load=1 (sampled regardless of en):
  - div_q <= div_in slice; cnt <= 0; out <= 0; tick <= 0.
  - A load in the same cycle as a terminal count wins: no tick, no toggle.
- en=0: cnt and out hold; tick <= 0.
- Terminal: en=1 and cnt >= div_q (>= so that an out-of-range count always recovers).
  - cnt <= 0; tick <= 1.
  - mode=0: out <= ~out.
  - mode=1: out <= 1.
- Count: en=1, cnt < div_q: cnt <= cnt+1; tick <= 0. mode=1: out <= 0; mode=0: out holds.
- Timing:
  - tick period = div_q+1 cycles; tick is high exactly 1 cycle.
  - Toggle-mode out period = 2*(div_q+1), 50% duty.
  - div_q=0: tick is continuously high; toggle out flips every cycle.
  - Latency: first tick appears div_q+1 cycles after the first enabled cycle following reset or load.
- Mode is sampled every cycle, with no glitch protection. Toggle->pulse with out=1: out falls next cycle unless that cycle is terminal. Pulse->toggle: out holds, then toggles at the next terminal.
- Counter never wraps, because it is bounded by div_q <= 2**CNT_W-1.
- Channels are fully independent unless the optional feature is compiled in.
- Async reset mid-count forces all outputs to 0 immediately and discards any loaded divisors.

Optional Feature:
- Macro: CLKDIV_ALIGN_EN.
- Defined: a load on any channel restarts every channel in the same cycle. Each channel gets cnt<=0, out<=0, tick<=0. Channels without load keep their div_q. This phase-aligns all channels.
- Undefined: load affects only its own channel.

Test Plan:
- CH=2, CNT_W=8, DEFAULT_DIV=3, en=2'b11, mode=0, release reset -> out[0], out[1] toggle every 4 cycles (period 8); tick high 1 cycle in every 4; first tick 4 cycles after release.
- load[0]=1 with div=0 -> from next cycle out[0] toggles every cycle and tick[0] stays high; channel 1 is unaffected (or restarts with CLKDIV_ALIGN_EN).
- mode[1]=1, load div=4 -> out[1]==tick[1], high 1 cycle in every 5; none for the first 4 cycles after load.
- en[0]=0 for 10 cycles with cnt=2, div=3 -> out and cnt frozen, tick 0; after re-enable the next tick comes after exactly 2 more cycles.
- Assert load[0] in the cycle cnt==div_q -> no tick, out[0]=0, count restarts from 0.
- Drop reset mid-run with out=1 -> out and tick are 0 immediately (before the next clk edge); after release, div_q=DEFAULT_DIV again.
